// File: rtl/mux2_arbiter_if.sv
// Handshake and data bundle between the two requesters and the shared 2-to-1 mux arbiter.
interface mux2_arbiter_if #(
  parameter int W = 1
);
  logic         req1;
  logic         req2;
  logic [W-1:0] x1;
  logic [W-1:0] x2;
  logic         gnt1;
  logic         gnt2;
  logic         s;
  logic [W-1:0] f;
  logic         valid;

  modport master (
    output req1, req2, x1, x2,
    input  gnt1, gnt2, s, f, valid
  );

  modport slave (
    input  req1, req2, x1, x2,
    output gnt1, gnt2, s, f, valid
  );
endinterface

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter for a shared 2-to-1 mux. It issues one-hot grants and drives the select.
// It registers the selected data with a valid flag, and a hold limit rotates the grant under contention.
module mux2_arbiter #(
  parameter int W        = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          reset,
  mux2_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, G1 = 2'd1, G2 = 2'd2} state_t;

  localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD) - 8'd1;
  localparam logic       HOLD_EN   = (MAX_HOLD != 0);

  state_t       state_r;
  state_t       next_state_s;
  logic [7:0]   hold_cnt_r;
  logic         last_served_r;   // 0: requester 1 served last, 1: requester 2
  logic         s_prev_r;
  logic         expire_s;
  logic         gnt1_s;
  logic         gnt2_s;
  logic         s_s;
  logic [W-1:0] f_r;
  logic         valid_r;

  // State, hold counter, fairness history and remembered select
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      hold_cnt_r    <= 8'd0;
      last_served_r <= 1'b1;
      s_prev_r      <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      s_prev_r <= s_s;
      if (next_state_s != state_r) begin
        hold_cnt_r <= 8'd0;
      end else if ((state_r != IDLE) && (hold_cnt_r != HOLD_MAX)) begin
        hold_cnt_r <= hold_cnt_r + 8'd1;
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
      if (state_r == G1) begin
        last_served_r <= 1'b0;
      end else if (state_r == G2) begin
        last_served_r <= 1'b1;
      end else begin
        last_served_r <= last_served_r;
      end
    end
  end

  // Next-state selection. A counter that saturated during a solo hold
  // still expires as soon as the other side starts asking.
  always_comb begin
    next_state_s = state_r;
    expire_s     = HOLD_EN && (hold_cnt_r >= HOLD_LAST);
    case (state_r)
      IDLE: begin
        if (bus.req1 && bus.req2) begin
          next_state_s = last_served_r ? G1 : G2;
        end else if (bus.req1) begin
          next_state_s = G1;
        end else if (bus.req2) begin
          next_state_s = G2;
        end else begin
          next_state_s = IDLE;
        end
      end
      G1: begin
        if (!bus.req1) begin
          next_state_s = bus.req2 ? G2 : IDLE;
        end else if (bus.req2 && expire_s) begin
          next_state_s = G2;
        end else begin
          next_state_s = G1;
        end
      end
      G2: begin
        if (!bus.req2) begin
          next_state_s = bus.req1 ? G1 : IDLE;
        end else if (bus.req1 && expire_s) begin
          next_state_s = G1;
        end else begin
          next_state_s = G2;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Grant and select decode
  always_comb begin
    gnt1_s = 1'b0;
    gnt2_s = 1'b0;
    s_s    = s_prev_r;
    case (state_r)
      G1: begin
        gnt1_s = 1'b1;
        s_s    = 1'b0;
      end
      G2: begin
        gnt2_s = 1'b1;
        s_s    = 1'b1;
      end
      default: begin
        gnt1_s = 1'b0;
        gnt2_s = 1'b0;
        s_s    = s_prev_r;
      end
    endcase
  end

  // Registered mux output, one cycle behind the grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_r     <= {W{1'b0}};
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        G1: begin
          f_r     <= bus.x1;
          valid_r <= 1'b1;
        end
        G2: begin
          f_r     <= bus.x2;
          valid_r <= 1'b1;
        end
        default: begin
          f_r     <= f_r;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt1  = gnt1_s;
  assign bus.gnt2  = gnt2_s;
  assign bus.s     = s_s;
  assign bus.f     = f_r;
  assign bus.valid = valid_r;
endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: three hold limits (8, 0, 1) share one stimulus stream,
// each checked every cycle against an ownership model plus hand-computed expectations.
module tb_mux2_arbiter;
  localparam int W  = 4;
  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         req1;
  logic         req2;
  logic [W-1:0] x1;
  logic [W-1:0] x2;

  int n_checks = 0;
  int n_fail   = 0;

  int lim   [NI] = '{8, 0, 1};
  int own   [NI] = '{0, 0, 0};
  int run   [NI] = '{0, 0, 0};
  int last  [NI] = '{2, 2, 2};
  int lastg [NI] = '{0, 0, 0};
  logic [W-1:0] mf [NI] = '{4'd0, 4'd0, 4'd0};
  logic         mv [NI] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  mux2_arbiter_if #(.W(W)) bus8 ();
  mux2_arbiter_if #(.W(W)) bus0 ();
  mux2_arbiter_if #(.W(W)) bus1 ();

  assign bus8.req1 = req1;  assign bus8.req2 = req2;  assign bus8.x1 = x1;  assign bus8.x2 = x2;
  assign bus0.req1 = req1;  assign bus0.req2 = req2;  assign bus0.x1 = x1;  assign bus0.x2 = x2;
  assign bus1.req1 = req1;  assign bus1.req2 = req2;  assign bus1.x1 = x1;  assign bus1.x2 = x2;

  mux2_arbiter #(.W(W), .MAX_HOLD(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  mux2_arbiter #(.W(W), .MAX_HOLD(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mux2_arbiter #(.W(W), .MAX_HOLD(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // Who owns the mux next, given current owner, cycles already held and requests
  function automatic int nxt(int o, int r, int ls, logic r1, logic r2, int lm);
    logic mine;
    logic other;
    if (o == 0) begin
      if (r1 && r2) return (ls == 1) ? 2 : 1;
      if (r1) return 1;
      if (r2) return 2;
      return 0;
    end
    mine  = (o == 1) ? r1 : r2;
    other = (o == 1) ? r2 : r1;
    if (!mine) return other ? (3 - o) : 0;
    if (other && (lm != 0) && (r + 1 >= lm)) return 3 - o;
    return o;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        own[i]   <= 0;
        run[i]   <= 0;
        last[i]  <= 2;
        lastg[i] <= 0;
        mf[i]    <= '0;
        mv[i]    <= 1'b0;
      end else begin
        own[i]   <= nxt(own[i], run[i], last[i], req1, req2, lim[i]);
        run[i]   <= ((own[i] != 0) && (nxt(own[i], run[i], last[i], req1, req2, lim[i]) == own[i]))
                    ? run[i] + 1 : 0;
        last[i]  <= (own[i] != 0) ? own[i] : last[i];
        lastg[i] <= (own[i] != 0) ? own[i] : lastg[i];
        mf[i]    <= (own[i] == 1) ? x1 : ((own[i] == 2) ? x2 : mf[i]);
        mv[i]    <= (own[i] != 0);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int i, input logic g1, input logic g2, input logic s,
                     input logic [W-1:0] f, input logic v);
    string p;
    p = $sformatf("hold%0d_", lim[i]);
    chk({p, "gnt1"},  int'(g1), int'(own[i] == 1));
    chk({p, "gnt2"},  int'(g2), int'(own[i] == 2));
    chk({p, "s"},     int'(s),  int'((own[i] == 2) || ((own[i] == 0) && (lastg[i] == 2))));
    chk({p, "f"},     int'(f),  int'(mf[i]));
    chk({p, "valid"}, int'(v),  int'(mv[i]));
  endtask

  always @(negedge clk) begin
    cmp(0, bus8.gnt1, bus8.gnt2, bus8.s, bus8.f, bus8.valid);
    cmp(1, bus0.gnt1, bus0.gnt2, bus0.s, bus0.f, bus0.valid);
    cmp(2, bus1.gnt1, bus1.gnt2, bus1.s, bus1.f, bus1.valid);
  end

  task automatic chk_zero8(input string tag);
    chk({tag, "_gnt1"},  int'(bus8.gnt1),  0);
    chk({tag, "_gnt2"},  int'(bus8.gnt2),  0);
    chk({tag, "_s"},     int'(bus8.s),     0);
    chk({tag, "_f"},     int'(bus8.f),     0);
    chk({tag, "_valid"}, int'(bus8.valid), 0);
  endtask

  initial begin
    int c0_g2;
    int c0_g1;
    reset = 1'b1; req1 = 1'b0; req2 = 1'b0; x1 = 4'd0; x2 = 4'd0;
    repeat (2) @(negedge clk);
    chk_zero8("por");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // lone requester 1
    req1 = 1'b1; x1 = 4'd1;
    @(negedge clk);
    chk("solo_c1_gnt1", int'(bus8.gnt1), 1);
    chk("solo_c1_s", int'(bus8.s), 0);
    chk("solo_c1_valid", int'(bus8.valid), 0);
    @(negedge clk);
    chk("solo_c2_f", int'(bus8.f), 1);
    chk("solo_c2_valid", int'(bus8.valid), 1);
    req1 = 1'b0;
    @(negedge clk);
    chk("solo_c3_gnt1", int'(bus8.gnt1), 0);
    chk("solo_c3_valid", int'(bus8.valid), 1);
    @(negedge clk);
    chk("solo_c4_valid", int'(bus8.valid), 0);

    // reset asserted while granted with both requesting: clears without a clock edge
    req1 = 1'b1; req2 = 1'b1; x1 = 4'd9; x2 = 4'd6;
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", int'(bus8.valid), 1);
    #2 reset = 1'b1;
    #1 chk_zero8("async_rst");
    @(negedge clk);
    reset = 1'b0;

    // tie from reset release: requester 1 first, rotation by hold limit
    c0_g2 = 0;
    c0_g1 = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      chk("rr8_gnt1", int'(bus8.gnt1), int'(((k - 1) / 8) % 2 == 0));
      chk("rr8_gnt2", int'(bus8.gnt2), int'(((k - 1) / 8) % 2 == 1));
      chk("rr1_gnt1", int'(bus1.gnt1), int'(k % 2 == 1));
      if (k == 9) chk("rr8_s_k9", int'(bus8.s), 1);
      c0_g2 += int'(bus0.gnt2);
      c0_g1 += int'(bus0.gnt1);
      x1 = 4'(k);
      x2 = 4'(15 - k);
    end
    chk("unl_gnt2_cycles", c0_g2, 0);
    chk("unl_gnt1_cycles", c0_g1, 50);

    // early release handover, counter restart, then reset mid-G2
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; req1 = 1'b1; req2 = 1'b0; x1 = 4'd3; x2 = 4'd5;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k >= 2) chk("hand_valid", int'(bus8.valid), 1);
      if (k == 1) begin
        chk("hand_k1_gnt1", int'(bus8.gnt1), 1);
        req2 = 1'b1;
      end
      if (k == 3) begin
        chk("hand_k3_f", int'(bus8.f), 3);
        req1 = 1'b0;
      end
      if (k == 4) begin
        chk("hand_k4_gnt2", int'(bus8.gnt2), 1);
        chk("hand_k4_f", int'(bus8.f), 3);
        req1 = 1'b1;
      end
      if (k == 5) chk("hand_k5_f", int'(bus8.f), 5);
      if (k == 11) chk("hand_k11_gnt2", int'(bus8.gnt2), 1);
      if (k == 12) chk("hand_k12_gnt1", int'(bus8.gnt1), 1);
      if (k == 20) begin
        chk("hand_k20_gnt2", int'(bus8.gnt2), 1);
        chk("hand_k20_s", int'(bus8.s), 1);
      end
    end
    #2 reset = 1'b1;
    #1 chk_zero8("mid_g2_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt1", int'(bus8.gnt1), 1);
    chk("post_rst_gnt2", int'(bus8.gnt2), 0);
    req1 = 1'b0; req2 = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 2-to-1 multiplexer (data inputs x1/x2, select s, output f).
- Two requesters compete for the mux. The block issues registered one-hot grants and drives the mux select.
- It registers the selected data with a valid flag.
- A hold limit forces a grant to rotate when the other side is waiting, so neither requester starves.

Parameters:
- W, 1: data width of x1, x2, f.
- MAX_HOLD, 8: maximum consecutive granted cycles while the other side requests. 0 = unlimited. Legal range 0..255.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req1  input  1  requester 1 wants the mux.
- req2  input  1  requester 2 wants the mux.
- x1  input  W  requester 1 data.
- x2  input  W  requester 2 data.
- gnt1  output  1  registered grant to requester 1.
- gnt2  output  1  registered grant to requester 2.
- s  output  1  mux select. 0 = x1, 1 = x2.
- f  output  W  registered mux output.
- valid  output  1  f holds data sampled under a grant.

Behaviour:
- Reset (async assert, sync deassert of effect at next edge):
  - State = IDLE; gnt1 = gnt2 = 0; s = 0; f = 0; valid = 0.
  - Hold counter = 0; last_served = 2, so requester 1 wins the first tie.
- States: IDLE, G1, G2. gnt1 = (state == G1); gnt2 = (state == G2). Grants are never both 1.
- s: 0 in G1, 1 in G2. In IDLE, s keeps its previous value.
- IDLE transitions:
  - req1 & !req2 -> G1.
  - req2 & !req1 -> G2.
  - Both -> the side not equal to last_served.
  - Neither -> stay in IDLE.
  - Grant appears the cycle after the request is sampled (1-cycle latency).
- In Gk (k = 1 or 2; other side = j):
  - last_served = k.
  - hold counter increments each cycle while the grant is held, saturating at MAX_HOLD.
  - reqk = 0 and reqj = 1 -> Gj directly, no idle bubble.
  - reqk = 0 and reqj = 0 -> IDLE.
  - reqk = 1, reqj = 1, MAX_HOLD != 0, and counter == MAX_HOLD-1 on this cycle -> Gj. Gk therefore lasts at most MAX_HOLD cycles.
  - Otherwise stay in Gk.
  - Counter clears to 0 on every state change.
- Counter is not compared while reqj = 0: a lone requester keeps the grant indefinitely.
- Data path, each edge:
  - f <= x1 if in G1, x2 if in G2, f unchanged in IDLE.
  - valid <= 1 in G1/G2, 0 in IDLE.
  - f/valid therefore lag the grant by one cycle: the x value present during a grant cycle appears on f the next cycle.
- Switch boundary: on a G1 -> G2 switch, the last x1 sample and the first x2 sample appear on f in consecutive cycles, with valid continuously 1.
- A request dropping in the same cycle as a hold expiry follows the reqk = 0 rule. The result is the same Gj.
- Reset mid-grant: grants, valid, and f clear immediately, without waiting for clk. last_served returns to 2.
- MAX_HOLD = 1 with both requesting: grants alternate every cycle.

Test Plan:
- Reset: assert reset with req1 = req2 = 1 -> gnt1 = gnt2 = 0, s = 0, f = 0, valid = 0, with no clock edge required.
- Single requester (W=1): req1 = 1 from cycle 0, x1 = 1 -> gnt1 = 1 at cycle 1, s = 0, f = 1 and valid = 1 at cycle 2. Drop req1 -> IDLE, and valid = 0 one cycle later.
- Simultaneous first request: req1 = req2 = 1 from reset release -> G1 first. Hold both with MAX_HOLD = 8 -> gnt1 for exactly 8 cycles, then gnt2 (s = 1) for 8 cycles, then G1 again, with no IDLE cycles.
- Early release handover: G1 active, req2 = 1, req1 drops after 3 cycles -> gnt2 the next cycle, and the hold counter restarts. f shows x1 samples, then x2 samples, with valid continuously 1.
- MAX_HOLD = 0 (unlimited): req1 = req2 = 1 for 50 cycles -> gnt1 held all 50 cycles and gnt2 never asserts.
- Reset mid-operation: in G2 with s = 1, pulse reset -> all outputs 0. Then req1 = req2 = 1 -> G1 wins, because last_served was reset.
